// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and helpers for matrix_multiply_gen (MATMUL_SATURATE_EN selects saturating output)
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } mm_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Address/counter width that never collapses to zero bits.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  // Sum of N full-width products cannot overflow this width.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + clog2(n);
  endfunction

  // Shift the accumulated sum down, then clamp or truncate to the element width.
  function automatic logic [63:0] scale_result(input logic [63:0] sum, input int shift, input int width);
    logic [63:0] shifted;
    logic [63:0] max_val;
    shifted = sum >> shift;
    max_val = (64'd1 << width) - 64'd1;
`ifdef MATMUL_SATURATE_EN
    if (shifted > max_val) shifted = max_val;
`endif
    return shifted & max_val;
  endfunction

endpackage

// File: rtl/matrix_multiply_gen_mac.sv
// rtl/matrix_multiply_gen_mac.sv - registered multiply-accumulate (matmul_mac) with clear-and-load and scaled result
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int RES_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  localparam int ACC_W = acc_width(WIDTH, N);

  logic [ACC_W-1:0]   acc;
  logic [2*WIDTH-1:0] product;
  logic [ACC_W-1:0]   sum;

  assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign sum     = acc + ACC_W'(product);
  // Result reflects the sum including the operand pair consumed this cycle.
  assign result  = WIDTH'(scale_result(64'(sum), RES_SHIFT, WIDTH));

  // Accumulate each valid product; the last term of a dot product clears acc for the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (valid) begin
      acc <= last ? '0 : sum;
    end
  end

endmodule

// File: rtl/matrix_multiply_gen.sv
// rtl/matrix_multiply_gen.sv - pipelined RES = A x B engine over synchronous RAMs (MATMUL_SATURATE_EN selects saturating output)
module matrix_multiply_gen
  import matmul_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int M              = 2,
  parameter int N              = 4,
  parameter int P              = 1,
  parameter int RES_SHIFT      = 0,
  parameter int A_depth_bits   = addr_bits(M * N),
  parameter int B_depth_bits   = addr_bits(N * P),
  parameter int RES_depth_bits = addr_bits(M * P)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Start,
  output logic                      Done,
  output logic                      A_read_en,
  output logic [A_depth_bits-1:0]   A_read_address,
  input  logic [WIDTH-1:0]          A_read_data_out,
  output logic                      B_read_en,
  output logic [B_depth_bits-1:0]   B_read_address,
  input  logic [WIDTH-1:0]          B_read_data_out,
  output logic                      RES_write_en,
  output logic [RES_depth_bits-1:0] RES_write_address,
  output logic [WIDTH-1:0]          RES_write_data_in
);

  localparam int IW = addr_bits(M);
  localparam int JW = addr_bits(P);
  localparam int KW = addr_bits(N);

  mm_state_t state, state_n;
  logic      drain_q;
  logic      issue;

  logic [IW-1:0] i_cnt;
  logic [JW-1:0] j_cnt;
  logic [KW-1:0] k_cnt;
  logic          i_last, j_last, k_last, last_elem;

  // Tags travelling alongside the RAM read: stage 1 = address cycle, stage 2 = data cycle.
  logic                      s1_valid, s1_last, s2_valid, s2_last;
  logic [RES_depth_bits-1:0] s1_res_addr, s2_res_addr;
  logic [WIDTH-1:0]          mac_result;

  assign i_last    = (i_cnt == IW'(M - 1));
  assign j_last    = (j_cnt == JW'(P - 1));
  assign k_last    = (k_cnt == KW'(N - 1));
  assign last_elem = i_last && j_last && k_last;

  // State register plus the one-bit drain timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      drain_q <= 1'b0;
    end else begin
      state   <= state_n;
      drain_q <= (state == ST_DRAIN) && !drain_q;
    end
  end

  // Next state and issue decision; an element is issued on every RUN cycle and on the accepting IDLE cycle.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          issue   = 1'b1;
          state_n = last_elem ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        if (last_elem) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_q) state_n = ST_FINISH;
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Issue stage: register RAM reads, advance i/j/k (k innermost) and launch the stage-1 tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A_read_en      <= 1'b0;
      B_read_en      <= 1'b0;
      A_read_address <= '0;
      B_read_address <= '0;
      i_cnt          <= '0;
      j_cnt          <= '0;
      k_cnt          <= '0;
      s1_valid       <= 1'b0;
      s1_last        <= 1'b0;
      s1_res_addr    <= '0;
    end else begin
      A_read_en <= issue;
      B_read_en <= issue;
      s1_valid  <= issue;
      s1_last   <= issue && k_last;
      if (issue) begin
        A_read_address <= A_depth_bits'(32'(i_cnt) * 32'(N) + 32'(k_cnt));
        B_read_address <= B_depth_bits'(32'(k_cnt) * 32'(P) + 32'(j_cnt));
        s1_res_addr    <= RES_depth_bits'(32'(i_cnt) * 32'(P) + 32'(j_cnt));
        if (k_last) begin
          k_cnt <= '0;
          if (j_last) begin
            j_cnt <= '0;
            i_cnt <= i_last ? '0 : i_cnt + 1'b1;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end else begin
          k_cnt <= k_cnt + 1'b1;
        end
      end else begin
        A_read_address <= '0;
        B_read_address <= '0;
      end
    end
  end

  // Data stage tags, RES write registers and the completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid          <= 1'b0;
      s2_last           <= 1'b0;
      s2_res_addr       <= '0;
      RES_write_en      <= 1'b0;
      RES_write_address <= '0;
      RES_write_data_in <= '0;
      Done              <= 1'b0;
    end else begin
      s2_valid     <= s1_valid;
      s2_last      <= s1_last;
      s2_res_addr  <= s1_res_addr;
      RES_write_en <= s2_valid && s2_last;
      if (s2_valid && s2_last) begin
        RES_write_address <= s2_res_addr;
        RES_write_data_in <= mac_result;
      end
      Done <= (state == ST_FINISH);
    end
  end

  matmul_mac #(
    .WIDTH     (WIDTH),
    .N         (N),
    .RES_SHIFT (RES_SHIFT)
  ) u_mac (
    .clk    (clk),
    .rst    (reset),
    .valid  (s2_valid),
    .last   (s2_last),
    .a      (A_read_data_out),
    .b      (B_read_data_out),
    .result (mac_result)
  );

endmodule

// File: doc/matrix_multiply_gen.md
Name: matrix_multiply_gen

Overview:
Parametrised matrix-multiply engine for the AXI Stream coprocessor: computes RES(MxP) = A(MxN) x B(NxP) with unsigned WIDTH-bit elements.
- Reads A_RAM and B_RAM, both synchronous-read with 1-cycle latency; issues one read pair per cycle, fully pipelined.
- Writes each scaled dot product to RES_RAM.
- Sits between the stream wrapper FSM (Start/Done) and the three RAMs.
- Generalises the fixed 2x4 by 4x1 unit to arbitrary M, N, P, with output scaling and a reset.

Parameters:
- WIDTH, 8, bits per element of A, B and RES.
- M, 2, rows of A and RES.
- N, 4, columns of A and rows of B (dot-product length), N >= 1.
- P, 1, columns of B and RES.
- RES_SHIFT, 0, right shift applied to each accumulated sum before writing; 8 gives divide-by-256.
- A_depth_bits, clog2(M*N), A_RAM address width.
- B_depth_bits, clog2(N*P), B_RAM address width.
- RES_depth_bits, clog2(M*P), RES_RAM address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Start  in  1  level; sampled only in IDLE.
- Done  out  1  one-cycle completion pulse.
- A_read_en  out  1  A_RAM read enable.
- A_read_address  out  A_depth_bits  row-major address i*N+k.
- A_read_data_out  in  WIDTH  A_RAM data, valid 1 cycle after address.
- B_read_en  out  1  B_RAM read enable.
- B_read_address  out  B_depth_bits  row-major address k*P+j.
- B_read_data_out  in  WIDTH  B_RAM data, valid 1 cycle after address.
- RES_write_en  out  1  RES_RAM write strobe.
- RES_write_address  out  RES_depth_bits  address i*P+j.
- RES_write_data_in  out  WIDTH  scaled result.

Behaviour:
Reset and clocking:
- One clock domain. Reset is asynchronous and active-high.
- On reset, every output is 0, all counters and the accumulator are 0, and the state is IDLE.
- Reset mid-operation aborts immediately with no further RES write.

Constants and ordering:
- ACC_WIDTH = 2*WIDTH + clog2(N); the accumulator can never overflow.
- E = M*P*N elements. Element order: i outer, j middle, k inner.

State machine:
- IDLE: outputs low. Start=1 at edge 0 -> RUN; element 0 is issued at edge 0.
- RUN: element e is issued at edge e (A/B en=1 with its addresses). After the last issue (e=E-1) -> DRAIN; en drop to 0 at edge E.
- DRAIN: the pipeline empties over 2 cycles -> FINISH.
- FINISH: Done=1 for exactly one cycle (registered at edge E+2) -> IDLE. Start is accepted again from edge E+3.

Datapath:
- Element e's operands are consumed at edge e+2: acc <= acc + A*B, full-width product.
- On consuming k=N-1, the same edge registers:
  - RES_write_en=1
  - RES_write_address = i*P+j
  - RES_write_data_in = (acc + product) >> RES_SHIFT, truncated to the low WIDTH bits
  - acc cleared to 0
- RES_write_en is a one-cycle strobe per result; exactly M*P writes per run.
- Back-to-back dot products carry no bubble. Clear-and-load when N=1 behaves the same way.

Boundary conditions:
- Start held high through completion does not retrigger until IDLE is re-entered.
- Start in any non-IDLE state is ignored.
- Counters wrap k->0, j->0, i->0 at their limits and are never left stale for the next run.

Optional Feature:
MATMUL_SATURATE_EN.
- Defined: a shifted sum exceeding 2^WIDTH-1 is written as 2^WIDTH-1.
- Undefined: the low WIDTH bits are written (truncate).
- Timing is identical in both builds.

Decomposition:
- Shared package matmul_pkg:
  - FSM state encoding (IDLE, RUN, DRAIN, FINISH)
  - ACC_WIDTH function
  - clog2 helper
  - scale/saturate function
- One natural sub-module, matmul_mac:
  - registered multiply-accumulate with clear-and-load input
  - emits the scaled/saturated result
- Top level keeps FSM, address counters and RES write registers.

Test Plan:
1. Default params (M=2, N=4, P=1); A=1..8, B=1,2,3,4; Start at edge 0 -> RES[0]=30, RES[1]=70; writes at edges 5 and 9; Done pulse registered at edge 10 only.
2. M=2, N=2, P=2; A=[1,2;3,4], B=[5,6;7,8] -> RES addr0..3 = 19, 22, 43, 50, in address order.
3. All A, B = 255, N=4, RES_SHIFT=8 -> written 248 without MATMUL_SATURATE_EN, 255 with it.
4. Assert reset at edge 6 of test 1 -> all outputs 0 asynchronously, no RES write, no Done. A fresh Start then reproduces 30 and 70.
5. Start held high continuously for 3 runs -> Done pulses at edges 10, 21, 32; each run produces identical writes.
6. Start pulsed again during RUN/DRAIN -> ignored; exactly M*P writes and one Done.
